// File: rtl/tristate_arb_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
package tristate_arb_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StOwn   = 2'd2,
    StTurn  = 2'd3
  } arb_state_e;

  // True when at most one bit is set (zero counts as valid).
  function automatic logic onehot0(input logic [15:0] v);
    return (v & (v - 16'd1)) == 16'd0;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_priority_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] cand;

  // Scan from last+1 upward; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = W'((32'(last) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter producing one-hot tristate enables with a dead turnaround
// between owners. Optional hold limit: define TRISTATE_ARB_HOLD_LIMIT_EN.
module tristate_bus_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         sel,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner_id,
  output logic                 hold_expired
);

  import tristate_arb_pkg::*;

  localparam int unsigned W = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("N must be in 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end
  if (TURN_CYCLES < 1 || TURN_CYCLES > 4) begin : g_bad_turn
    $error("TURN_CYCLES must be in 1..4");
  end

  arb_state_e   state_q, state_d;
  logic [W-1:0] owner_q, owner_d;
  logic [W-1:0] last_q, last_d;
  logic [2:0]   turn_q, turn_d;
  logic         pick_valid;
  logic [W-1:0] pick_idx;
  logic [N-1:0] owner_oh;

`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;
  logic       hexp_q, hexp_d;
`endif

  rr_priority_picker #(
    .N (N)
  ) u_picker (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= W'(N - 1);
      turn_q  <= '0;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
      hexp_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
      hexp_q  <= hexp_d;
`endif
    end
  end

  // Next-state logic; requests are only looked at while idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    turn_d  = turn_q;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
    hexp_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StSetup;
          owner_d = pick_idx;
          // Pointer moves at grant time, so the owner is last in line next round.
          last_d  = pick_idx;
        end
      end
      StSetup: begin
        if (req[owner_q]) begin
          state_d = StOwn;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = StTurn;
          turn_d  = '0;
        end
      end
      StOwn: begin
        if (!req[owner_q]) begin
          state_d = StTurn;
          turn_d  = '0;
        end
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
        else if (hold_q == 8'(MAX_HOLD - 1)) begin
          // MAX_HOLD sel cycles completed: expel the owner.
          state_d = StTurn;
          turn_d  = '0;
          hexp_d  = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      StTurn: begin
        if (turn_q == 3'(TURN_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          turn_d = turn_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign owner_oh = N'(1) << owner_q;

  // Outputs decoded purely from registered state.
  always_comb begin
    gnt  = '0;
    sel  = '0;
    busy = (state_q != StIdle);
    if (state_q == StSetup || state_q == StOwn) begin
      gnt = owner_oh;
    end
    if (state_q == StOwn) begin
      sel = owner_oh;
    end
  end

  assign owner_id = owner_q;

`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
  assign hold_expired = hexp_q;
`else
  assign hold_expired = 1'b0;
`endif

  a_sel_onehot: assert property (@(posedge clk) disable iff (rst) onehot0(16'(sel)));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) onehot0(16'(gnt)));
  a_sel_in_gnt: assert property (@(posedge clk) disable iff (rst) (sel & ~gnt) == '0);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench for tristate_bus_arbiter (N=4, MAX_HOLD=8, TURN_CYCLES=1).
// Honours TRISTATE_ARB_HOLD_LIMIT_EN for the hold-limit scenario.
module tb_tristate_bus_arbiter;

  import tristate_arb_pkg::*;

  localparam int N        = 4;
  localparam int BW       = 2;
  localparam int MAX_HOLD = 8;
  localparam int TURN     = 1;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  localparam int PIdle = 0, PSetup = 1, POwn = 2, PTurn = 3;

  logic          clk, rst;
  logic [N-1:0]  req, gnt, sel;
  logic          busy, hold_expired;
  logic [BW-1:0] owner_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  tristate_bus_arbiter #(
    .N           (N),
    .MAX_HOLD    (MAX_HOLD),
    .TURN_CYCLES (TURN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .sel          (sel),
    .busy         (busy),
    .owner_id     (owner_id),
    .hold_expired (hold_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, owner, priority pointer, timers.
  typedef struct packed {
    int ph;
    int own;
    int last;
    int left;
    int held;
    bit hx;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t s, logic [N-1:0] r, logic rs);
    mdl_t n = s;
    n.hx = 1'b0;
    if (rs) begin
      n.ph = PIdle; n.own = 0; n.last = N - 1; n.left = 0; n.held = 0;
      return n;
    end
    case (s.ph)
      PIdle: begin
        for (int i = 1; i <= N; i++) begin
          int c = (s.last + i) % N;
          if (n.ph == PIdle && r[c[BW-1:0]]) begin
            n.ph = PSetup; n.own = c; n.last = c;
          end
        end
      end
      PSetup: begin
        if (r[s.own[BW-1:0]]) begin n.ph = POwn; n.held = 0; end
        else begin n.ph = PTurn; n.left = TURN; end
      end
      POwn: begin
        n.held = s.held + 1;
        if (!r[s.own[BW-1:0]]) begin n.ph = PTurn; n.left = TURN; end
        else if (HoldEn && n.held == MAX_HOLD) begin
          n.ph = PTurn; n.left = TURN; n.hx = 1'b1;
        end
      end
      default: begin
        n.left = s.left - 1;
        if (n.left == 0) n.ph = PIdle;
      end
    endcase
    return n;
  endfunction

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v = 1;
    return v << i;
  endfunction

  function automatic int oh2int(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    m = step(m, req, rst);
  end

  // Per-cycle compare against the model plus invariant checks.
  int last_id = -1;
  int zrun    = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("gnt", 32'(gnt), (m.ph == PSetup || m.ph == POwn) ? 32'(oh(m.own)) : 32'd0);
      check("sel", 32'(sel), (m.ph == POwn) ? 32'(oh(m.own)) : 32'd0);
      check("busy", 32'(busy), 32'(m.ph != PIdle));
      check("owner_id", 32'(owner_id), 32'(m.own));
      check("hold_expired", 32'(hold_expired), 32'(m.hx));
      check("sel_onehot", 32'(onehot0(16'(sel))), 32'd1);
      check("gnt_onehot", 32'(onehot0(16'(gnt))), 32'd1);
      if (sel != '0) begin
        if (last_id >= 0 && zrun > 0) check("sel_gap_ge3", 32'(zrun >= 3), 32'd1);
        last_id = oh2int(sel);
        zrun    = 0;
      end else begin
        zrun++;
      end
      if (rst) begin
        last_id = -1;
        zrun    = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_sel(input string name);
    int n = 0;
    while (sel == '0 && n < 20) begin tick(); n++; end
    if (n >= 20) check(name, 32'(sel), 32'hffff_ffff);
  endtask

  initial begin
    int exp_ord[5];
    int gap, id, c1, hx, n;
    logic [N-1:0] p;
    exp_ord = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = 4'b1111;

    // Reset with all requests asserted.
    tick();
    chk_en = 1'b1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner_id), 32'd0);
    tick();
    rst = 1'b0;
    req = '0;
    tick();

    // Single request.
    req = 4'b0100;
    tick();
    check("single_gnt_setup", 32'(gnt), 32'h4);
    check("single_sel_setup", 32'(sel), 32'h0);
    tick();
    check("single_sel_own", 32'(sel), 32'h4);
    check("single_owner", 32'(owner_id), 32'd2);
    tick();
    tick();
    req = '0;
    tick();
    check("release_gnt", 32'(gnt), 32'h0);
    check("release_sel", 32'(sel), 32'h0);
    check("release_busy", 32'(busy), 32'd1);
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Round robin with all requesters active.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      n   = 0;
      while (sel == '0 && n < 20) begin tick(); gap++; n++; end
      if (n >= 20) check("rr_timeout", 32'(sel), 32'hffff_ffff);
      id = oh2int(sel);
      check("rr_owner", 32'(id), 32'(exp_ord[k]));
      if (k > 0) check("rr_gap", 32'(gap), 32'd3);
      tick();
      tick();
      p = req;
      p[id[BW-1:0]] = 1'b0;
      req = p;
      tick();
      req = 4'b1111;
    end

    // Hold limit.
    do_reset();
    req = 4'b0011;
    wait_sel("hold_timeout");
    c1 = 0;
    hx = 0;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
    for (int t = 0; t < 14; t++) begin
      if (sel == 4'b0001) c1++;
      if (hold_expired) hx++;
      if (t == 8) check("hold_pulse", 32'(hold_expired), 32'd1);
      if (t == 11) check("hold_next_owner", 32'(sel), 32'h2);
      tick();
    end
    check("hold_own_cycles", 32'(c1), 32'd8);
    check("hold_pulse_count", 32'(hx), 32'd1);
`else
    for (int t = 0; t < 100; t++) begin
      if (sel == 4'b0001) c1++;
      if (hold_expired) hx++;
      tick();
    end
    check("nohold_own_cycles", 32'(c1), 32'd100);
    check("nohold_pulses", 32'(hx), 32'd0);
`endif

    // Abort during setup.
    do_reset();
    req = 4'b0100;
    tick();
    check("abort_gnt_setup", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check("abort_sel", 32'(sel), 32'h0);
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_busy_turn", 32'(busy), 32'd1);
    tick();
    check("abort_busy_idle", 32'(busy), 32'd0);
    check("abort_sel_idle", 32'(sel), 32'h0);

    // Reset in the middle of ownership.
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    check("midrst_sel_own", 32'(sel), 32'h2);
    rst = 1'b1;
    tick();
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_owner", 32'(owner_id), 32'd0);
    rst = 1'b0;
    req = '0;
    tick();

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      req = N'($urandom);
      tick();
    end
    req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
